// File: rtl/dff_bist_pkg.sv
// Shared types and constants for the D flip-flop BIST controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dff_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RST   = 3'd1,
    RUN   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int LFSR_W = 16;

  // x^16+x^14+x^13+x^11+1 in Galois (left-shift) notation. The pattern
  // generator is a right-shifting Fibonacci register, which taps the
  // bit-reversed mask: bits 0,2,3,5.
  localparam logic [LFSR_W-1:0] LFSR_TAP_MASK     = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

  function automatic logic [LFSR_W-1:0] bit_rev(input logic [LFSR_W-1:0] v);
    logic [LFSR_W-1:0] r;
    r = '0;
    for (int i = 0; i < LFSR_W; i++) begin
      r[i] = v[LFSR_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/dff_bist_lfsr.sv
// Pseudo-random pattern source: right-shifting Fibonacci LFSR.
// Latency: new state visible the cycle after load/advance.
// Backpressure: none; holds its state when neither load nor advance is set.
// Ports: clk, reset (async, active-high), load (reload SEED, wins over
// advance), advance (one shift), state (current register contents).
module bist_lfsr
  import dff_bist_pkg::*;
#(
  parameter int                 WIDTH = LFSR_W,
  parameter logic [WIDTH-1:0]   SEED  = LFSR_DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(bit_rev(LFSR_TAP_MASK));

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = SEED;
    end else if (advance) begin
      // Feedback enters at the MSB while the register shifts toward bit 0.
      state_d = {^(state_q & TAPS), state_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/dff_bist.sv
// BIST controller for one D flip-flop: reset it, stream LFSR bits into d,
// check q (and optionally qb) one clock later, report pass/err_count.
// Latency: busy RST_CYCLES+NUM_VECTORS+1 cycles after start, then done pulse.
// Backpressure: none; start is ignored while a test is in flight.
// Ports: clk, reset (async, active-high), start; dut_reset/dut_d drive the
// flop, dut_q/dut_qb come back from it; busy, done, pass, err_count report.
// Option: define DFF_BIST_QB_CHECK_EN to also require dut_qb == ~dut_q.
module dff_bist
  import dff_bist_pkg::*;
#(
  parameter int                NUM_VECTORS = 64,
  parameter int                RST_CYCLES  = 2,
  parameter logic [LFSR_W-1:0] SEED        = 16'hACE1,
  parameter int                ERR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             dut_reset,
  output logic             dut_d,
  input  logic             dut_q,
  input  logic             dut_qb,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_DEFAULT_SEED : SEED;
  localparam int MAXC  = (RST_CYCLES > NUM_VECTORS) ? RST_CYCLES : NUM_VECTORS;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(NUM_VECTORS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic             d_prev_q, d_prev_d;
  logic             dut_reset_q, dut_d_q, busy_q, done_q;

  logic              start_acc;
  logic              cmp_en;
  logic              exp_q;
  logic              mismatch;
  logic [LFSR_W-1:0] lfsr_state;
  logic              unused_lfsr;

  assign start_acc   = (state_q == IDLE) && start;
  assign unused_lfsr = ^lfsr_state[LFSR_W-1:1];

  bist_lfsr #(
    .WIDTH (LFSR_W),
    .SEED  (SEED_EFF)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (start_acc),
    .advance (state_d == RUN),
    .state   (lfsr_state)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = RST;
      end
      RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (cnt_q == RUN_LAST) begin
          state_d = CHECK;
          cnt_d   = '0;
        end
      end
      CHECK: begin
        state_d = DONE;
        cnt_d   = '0;
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The flop must read 0 at the end of reset; afterwards q must equal the
  // bit driven one cycle earlier, which d_prev holds.
  always_comb begin
    cmp_en = ((state_q == RST) && (cnt_q == RST_LAST)) ||
             (state_q == RUN) || (state_q == CHECK);
    exp_q  = (state_q == RST) ? 1'b0 : d_prev_q;
  end

`ifdef DFF_BIST_QB_CHECK_EN
  // A q error and a qb error in the same cycle still count once.
  assign mismatch = cmp_en && ((dut_q != exp_q) || (dut_qb != ~dut_q));
`else
  logic unused_qb;
  assign unused_qb = dut_qb;
  assign mismatch  = cmp_en && (dut_q != exp_q);
`endif

  always_comb begin
    err_d    = err_q;
    pass_d   = pass_q;
    d_prev_d = d_prev_q;
    if (start_acc) begin
      err_d    = '0;
      pass_d   = 1'b0;
      d_prev_d = 1'b0;
    end else begin
      if (mismatch && (err_q != '1)) err_d = err_q + ERR_W'(1);
      if (state_q == RUN) d_prev_d = dut_d_q;
      // Latched on entry to DONE so it is already valid alongside done.
      if (state_d == DONE) pass_d = (err_d == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= '0;
      pass_q      <= 1'b0;
      d_prev_q    <= 1'b0;
      dut_reset_q <= 1'b1;
      dut_d_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      pass_q      <= pass_d;
      d_prev_q    <= d_prev_d;
      dut_reset_q <= (state_d == RST);
      // The LFSR advances on this same edge, so the next RUN cycle sees a new bit.
      dut_d_q     <= (state_d == RUN) ? lfsr_state[0] : 1'b0;
      busy_q      <= (state_d == RST) || (state_d == RUN) || (state_d == CHECK);
      done_q      <= (state_d == DONE);
    end
  end

  assign dut_reset = dut_reset_q;
  assign dut_d     = dut_d_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_dff_bist.sv
module tb_dff_bist;

  localparam int NV = 64;
  localparam int RC = 2;
  localparam int BUSY_LEN = NV + RC + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  int   mode = 0;  // 0 good, 1 q stuck-0, 2 q/qb inverted, 3 qb tied to q

  logic       dut_reset0, dut_d0, q0, qb0, busy0, done0, pass0;
  logic [7:0] err0;
  logic       dut_reset1, dut_d1, q1, qb1, busy1, done1, pass1;
  logic [3:0] err1;
  logic       ff0, ff1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dff_bist #(.NUM_VECTORS(NV), .RST_CYCLES(RC), .SEED(16'hACE1), .ERR_W(8)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .dut_reset(dut_reset0), .dut_d(dut_d0), .dut_q(q0), .dut_qb(qb0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0)
  );

  dff_bist #(.NUM_VECTORS(NV), .RST_CYCLES(RC), .SEED(16'hACE1), .ERR_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start),
    .dut_reset(dut_reset1), .dut_d(dut_d1), .dut_q(q1), .dut_qb(qb1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
  );

  // Flop-under-test models: synchronous reset, one clock of latency.
  always @(posedge clk) ff0 <= dut_reset0 ? 1'b0 : dut_d0;
  always @(posedge clk) ff1 <= dut_reset1 ? 1'b0 : dut_d1;

  always_comb begin
    q0  = (mode == 1) ? 1'b0 : (mode == 2) ? ~ff0 : ff0;
    qb0 = (mode == 3) ? q0 : ~q0;
    q1  = (mode == 1) ? 1'b0 : (mode == 2) ? ~ff1 : ff1;
    qb1 = (mode == 3) ? q1 : ~q1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  task automatic run_test(input bit extra, output int bc, output int dn, output int dpos,
                          output logic [63:0] ds, output logic [7:0] e0, output logic p0,
                          output logic [3:0] e1, output logic p1);
    bc = 0; dn = 0; dpos = -1; ds = '0; e0 = '0; p0 = 1'b0; e1 = '0; p1 = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (busy0) begin
        if (bc >= RC && bc < RC + NV) ds[bc-RC] = dut_d0;
        bc++;
      end
      if (done0) begin
        dn++; dpos = c; e0 = err0; p0 = pass0; e1 = err1; p1 = pass1;
      end
      // Extra start requests in a RUN cycle and in the DONE cycle.
      start = extra && ((c == 20) || done0);
      tick();
    end
    start = 1'b0;
  endtask

  typedef struct {
    string name;
    int    mode;
    bit    extra;
    int    exp_err;
    logic  exp_pass;
    int    exp_err4;
    logic  exp_pass4;
  } vec_t;

  vec_t        vecs[5];
  logic [63:0] exp_stream;
  logic [15:0] s;
  int          ones;
  int          bc, dn, dpos;
  logic [63:0] ds;
  logic [7:0]  e0;
  logic [3:0]  e1;
  logic        p0, p1;

  initial begin
    s = 16'hACE1;
    for (int k = 0; k < NV; k++) begin
      exp_stream[k] = s[0];
      s = lfsr_step(s);
    end
    ones = $countones(exp_stream);

    vecs[0] = '{"good",        0, 1'b0, 0,  1'b1, 0, 1'b1};
    vecs[1] = '{"stuck0",      1, 1'b0, ones, 1'b0, (ones > 15) ? 15 : ones, 1'b0};
    vecs[2] = '{"inverted",    2, 1'b0, 66, 1'b0, 15, 1'b0};
`ifdef DFF_BIST_QB_CHECK_EN
    vecs[3] = '{"qb_eq_q",     3, 1'b0, 66, 1'b0, 15, 1'b0};
`else
    vecs[3] = '{"qb_eq_q",     3, 1'b0, 0,  1'b1, 0, 1'b1};
`endif
    vecs[4] = '{"extra_start", 0, 1'b1, 0,  1'b1, 0, 1'b1};

    // Reset state.
    reset = 1'b1;
    tick(); tick();
    check("rst_dut_reset", 64'(dut_reset0), 64'd1);
    check("rst_dut_d",     64'(dut_d0),     64'd0);
    check("rst_busy",      64'(busy0),      64'd0);
    check("rst_done",      64'(done0),      64'd0);
    check("rst_pass",      64'(pass0),      64'd0);
    check("rst_err",       64'(err0),       64'd0);
    reset = 1'b0;
    tick();
    check("idle_dut_reset", 64'(dut_reset0), 64'd0);

    for (int i = 0; i < 5; i++) begin
      mode = vecs[i].mode;
      run_test(vecs[i].extra, bc, dn, dpos, ds, e0, p0, e1, p1);
      check({vecs[i].name, "_busy_len"}, 64'(bc),   64'(BUSY_LEN));
      check({vecs[i].name, "_done_cnt"}, 64'(dn),   64'd1);
      check({vecs[i].name, "_done_pos"}, 64'(dpos), 64'(BUSY_LEN));
      check({vecs[i].name, "_stream"},   ds,        exp_stream);
      check({vecs[i].name, "_err"},      64'(e0),   64'(vecs[i].exp_err));
      check({vecs[i].name, "_pass"},     64'(p0),   64'(vecs[i].exp_pass));
      check({vecs[i].name, "_err4"},     64'(e1),   64'(vecs[i].exp_err4));
      check({vecs[i].name, "_pass4"},    64'(p1),   64'(vecs[i].exp_pass4));
      check({vecs[i].name, "_err_held"}, 64'(err0), 64'(vecs[i].exp_err));
      check({vecs[i].name, "_pass_hold"},64'(pass0),64'(vecs[i].exp_pass));
    end

    // Abort in the 10th RUN cycle with q stuck at 0. Seed low byte 8'hE1
    // emerges LSB first: bits 1,0,0,0,0,1,1,1, so four errors are counted.
    mode  = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 11; c++) tick();
    check("abort_busy_before", 64'(busy0), 64'd1);
    check("abort_err_before",  64'(err0),  64'd4);
    reset = 1'b1;
    #2;
    check("abort_dut_reset", 64'(dut_reset0), 64'd1);
    check("abort_busy",      64'(busy0),      64'd0);
    check("abort_err",       64'(err0),       64'd0);
    check("abort_done",      64'(done0),      64'd0);
    tick();
    reset = 1'b0;
    tick();
    mode = 0;
    run_test(1'b0, bc, dn, dpos, ds, e0, p0, e1, p1);
    check("rerun_busy_len", 64'(bc), 64'(BUSY_LEN));
    check("rerun_done_cnt", 64'(dn), 64'd1);
    check("rerun_pass",     64'(p0), 64'd1);
    check("rerun_err",      64'(e0), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dff_bist.md
# dff_bist

Built-in self-test controller for a single D flip-flop cell (`dff`: ports clk, reset, d, q, qb). On a start pulse it holds the flop in reset, then drives a pseudo-random bit stream into `d`. It predicts `q` one clock later, checks `q`/`qb` every cycle, and reports pass/fail with an error count. It sits beside the flop under test on the same clock and replaces the manual stimulus/display sequence with an on-chip driver and checker.

## Interface
Parameters:
- `NUM_VECTORS`, 64: number of RUN cycles (≥1).
- `RST_CYCLES`, 2: cycles the DUT reset is held (≥1).
- `SEED`, 16'hACE1: LFSR seed; 0 is replaced by 16'hACE1.
- `ERR_W`, 8: error counter width.

Ports:
- `clk` in 1: single clock; the DUT shares it.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle start request; ignored while busy.
- `dut_reset` out 1: reset to DUT.
- `dut_d` out 1: data to DUT.
- `dut_q` in 1: DUT q.
- `dut_qb` in 1: DUT qb.
- `busy` out 1: high in RST/RUN/CHECK.
- `done` out 1: one-cycle pulse at end of test.
- `pass` out 1: result, valid from `done` until next `start`.
- `err_count` out ERR_W: saturating mismatch count.

## Operation
- FSM states and transitions:
  - IDLE → RST on `start`.
  - RST → RUN after RST_CYCLES cycles.
  - RUN → CHECK after NUM_VECTORS cycles.
  - CHECK → DONE (1 cycle).
  - DONE → IDLE (1 cycle).
- Reset values:
  - state=IDLE, dut_reset=1, dut_d=0, busy=0, done=0, pass=0, err_count=0.
  - LFSR=SEED, d_prev=0.
- IDLE: dut_reset=0, dut_d=0. A `start` clears err_count and pass, reloads the LFSR with SEED, and clears d_prev.
- RST: dut_reset=1. In the last RST cycle, check q==0 (and qb==1 if enabled); a mismatch adds 1.
- RUN:
  - dut_reset=0, dut_d=lfsr[0].
  - Each cycle compare dut_q with d_prev, the bit driven in the previous cycle. The first RUN cycle compares against 0.
  - Then d_prev←dut_d and the LFSR advances.
- CHECK: dut_d=0; compare dut_q with d_prev (the final vector).
- DONE: done=1 for one cycle; pass=(err_count==0) is registered here and held in IDLE.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifts right, feedback = b0^b2^b3^b5 into b15.
- Each compare adds at most 1 to err_count per cycle; err_count saturates at 2^ERR_W−1.
- `start` during RST/RUN/CHECK/DONE is ignored.
- Asserting `reset` mid-test aborts to IDLE with all reset values. The DUT is held in reset (dut_reset=1) while `reset` is high.

## Timing
- All outputs are registered; none depends combinationally on `start`, `dut_q` or `dut_qb`.
- `busy` rises the cycle after `start` is sampled.
- Total test = RST_CYCLES + NUM_VECTORS + 1 cycles busy, then `done` in the next cycle.
- Each compare samples `dut_q`/`dut_qb` at the same edge that loads the next `dut_d`. DUT latency is exactly one clock.
- `pass` and `err_count` are stable from the `done` cycle until the cycle after the next accepted `start`.

## Configuration
- `DFF_BIST_QB_CHECK_EN` defined:
  - every compare (RST last cycle, RUN, CHECK) also checks dut_qb == ~dut_q;
  - a cycle with both a q error and a qb error still counts 1.
- Undefined: dut_qb is unused (lint-waived) and only q is checked.

## Structure
- Package `dff_bist_pkg` holds:
  - state enum (IDLE, RST, RUN, CHECK, DONE);
  - LFSR width 16, tap mask 16'hB400 and default seed 16'hACE1.
- Sub-module `bist_lfsr`: parameters WIDTH, SEED; inputs clk, reset, load, advance; output state. The pattern source sits there and the FSM/checker stays in `dff_bist`.

## Test plan
- Good DFF, NUM_VECTORS=64, start → busy for 67 cycles, done pulse, pass=1, err_count=0.
- DUT q stuck at 0 → err_count = number of 1s among the 64 driven bits (model-computed from LFSR 16'hACE1), pass=0.
- Build with DFF_BIST_QB_CHECK_EN, qb tied equal to q → err_count=66 (every compare), pass=0. Without the macro the same bench gives pass=1.
- ERR_W=4, q inverted → err_count saturates at 15, no wrap.
- Assert `reset` in the 10th RUN cycle → dut_reset=1, busy=0, err_count=0. A new start then gives a full 67-cycle test with pass=1.
- `start` pulsed again during RUN and during DONE → ignored; exactly one done pulse per accepted start.
